// File: rtl/audio_dma_tile_sched.sv
// rtl/audio_dma_tile_sched.sv - tile scheduler sequencing DMA read, compute and DMA write per tile
module audio_dma_tile_sched #(
  parameter int          TILE_W   = 16,
  parameter logic [2:0]  DMA_SIZE = 3'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_done,
  input  logic [31:0]       cfg_src_base,
  input  logic [31:0]       cfg_dst_base,
  input  logic [31:0]       cfg_tile_len,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              rd_beat,
  output logic              comp_start,
  input  logic              comp_done,
  output logic              dma_write_ctrl_valid,
  input  logic              dma_write_ctrl_ready,
  output logic [31:0]       dma_write_ctrl_data_index,
  output logic [31:0]       dma_write_ctrl_data_length,
  output logic [2:0]        dma_write_ctrl_data_size,
  input  logic              wr_beat,
  output logic              acc_done,
  output logic [31:0]       debug
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_COMP    = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            state;
  logic [31:0]       src_base;
  logic [31:0]       dst_base;
  logic [31:0]       tile_len;
  logic [TILE_W-1:0] num_tiles;
  logic [TILE_W-1:0] tile;
  logic [31:0]       offset;
  logic [31:0]       beat_cnt;
  logic              ovf;

  logic beat_last;
  logic tile_last;
  logic stray;

  // Offset is an accumulator of tile_len, so indices are plain wrapping sums.
  assign dma_read_ctrl_data_index   = src_base + offset;
  assign dma_read_ctrl_data_length  = tile_len;
  assign dma_read_ctrl_data_size    = DMA_SIZE;
  assign dma_write_ctrl_data_index  = dst_base + offset;
  assign dma_write_ctrl_data_length = tile_len;
  assign dma_write_ctrl_data_size   = DMA_SIZE;

  assign beat_last = ((beat_cnt + 32'd1) == tile_len);
  assign tile_last = (tile == (num_tiles - TILE_W'(1)));
  assign stray     = (rd_beat && (state != S_RD_DATA)) || (wr_beat && (state != S_WR_DATA));

  assign debug = {1'b0, state, ovf, 11'd0, 16'(tile)};

  // Job sequencer: one pass of read request, read beats, compute, write request, write beats per tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= S_IDLE;
      src_base             <= 32'd0;
      dst_base             <= 32'd0;
      tile_len             <= 32'd0;
      num_tiles            <= '0;
      tile                 <= '0;
      offset               <= 32'd0;
      beat_cnt             <= 32'd0;
      ovf                  <= 1'b0;
      dma_read_ctrl_valid  <= 1'b0;
      dma_write_ctrl_valid <= 1'b0;
      comp_start           <= 1'b0;
      acc_done             <= 1'b0;
    end else begin
      comp_start <= 1'b0;
      if (stray) ovf <= 1'b1;
      case (state)
        S_IDLE: begin
          if (conf_done) begin
            src_base  <= cfg_src_base;
            dst_base  <= cfg_dst_base;
            tile_len  <= cfg_tile_len;
            num_tiles <= cfg_num_tiles;
            tile      <= '0;
            offset    <= 32'd0;
            beat_cnt  <= 32'd0;
            ovf       <= 1'b0;
            if ((cfg_tile_len == 32'd0) || (cfg_num_tiles == '0)) begin
              state <= S_DONE;
            end else begin
              state               <= S_RD_REQ;
              dma_read_ctrl_valid <= 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (dma_read_ctrl_ready) begin
            dma_read_ctrl_valid <= 1'b0;
            state               <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rd_beat) begin
            if (beat_last) begin
              beat_cnt   <= 32'd0;
              comp_start <= 1'b1;
              state      <= S_COMP;
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
        end
        S_COMP: begin
          // A done coincident with our own start pulse belongs to no tile.
          if (comp_done && !comp_start) begin
            dma_write_ctrl_valid <= 1'b1;
            state                <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (dma_write_ctrl_ready) begin
            dma_write_ctrl_valid <= 1'b0;
            state                <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (wr_beat) begin
            if (beat_last) begin
              beat_cnt <= 32'd0;
              if (tile_last) begin
                acc_done <= 1'b1;
                state    <= S_DONE;
              end else begin
                tile                <= tile + TILE_W'(1);
                offset              <= offset + tile_len;
                dma_read_ctrl_valid <= 1'b1;
                state               <= S_RD_REQ;
              end
            end else begin
              beat_cnt <= beat_cnt + 32'd1;
            end
          end
        end
        S_DONE: begin
          // Entered with acc_done already set after a real job, clear on a degenerate one.
          if (acc_done) begin
            acc_done <= 1'b0;
            state    <= S_IDLE;
          end else begin
            acc_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dma_tile_sched.sv
// tb/tb_audio_dma_tile_sched.sv - self-checking bench for audio_dma_tile_sched
module tb_audio_dma_tile_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        conf_done;
  logic [31:0] cfg_src_base, cfg_dst_base, cfg_tile_len;
  logic [15:0] cfg_num_tiles;
  logic        rd_valid, rd_ready, wr_valid, wr_ready;
  logic [31:0] rd_index, rd_length, wr_index, wr_length;
  logic [2:0]  rd_size, wr_size;
  logic        rd_beat, wr_beat, comp_start, comp_done, acc_done;
  logic [31:0] debug;

  audio_dma_tile_sched #(.TILE_W(16), .DMA_SIZE(3'd3)) dut (
    .clk(clk), .rst(rst), .conf_done(conf_done),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .cfg_tile_len(cfg_tile_len), .cfg_num_tiles(cfg_num_tiles),
    .dma_read_ctrl_valid(rd_valid), .dma_read_ctrl_ready(rd_ready),
    .dma_read_ctrl_data_index(rd_index), .dma_read_ctrl_data_length(rd_length),
    .dma_read_ctrl_data_size(rd_size), .rd_beat(rd_beat),
    .comp_start(comp_start), .comp_done(comp_done),
    .dma_write_ctrl_valid(wr_valid), .dma_write_ctrl_ready(wr_ready),
    .dma_write_ctrl_data_index(wr_index), .dma_write_ctrl_data_length(wr_length),
    .dma_write_ctrl_data_size(wr_size), .wr_beat(wr_beat),
    .acc_done(acc_done), .debug(debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Job-level model: request k of a job targets base + k*len.
  logic [31:0] m_src, m_dst, m_len;
  logic [15:0] m_tiles;
  int          m_rd_n, m_wr_n, m_cs, m_acc;
  bit          prev_cs, prev_acc;
  logic [31:0] cap_rd [0:7];
  logic [31:0] cap_wr [0:7];
  int          cap_rd_n, cap_wr_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of the ctrl channels and pulses against the model.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_valid) begin
        chk("rd_index", rd_index, m_src + 32'(m_rd_n) * m_len);
        chk("rd_length", rd_length, m_len);
        chk("rd_size", {29'd0, rd_size}, 32'd3);
        chk("rd_count_bound", {31'd0, (m_rd_n < int'(m_tiles))}, 32'd1);
        chk("rd_wr_exclusive", {31'd0, wr_valid}, 32'd0);
        if (rd_ready) m_rd_n++;
      end
      if (wr_valid) begin
        chk("wr_index", wr_index, m_dst + 32'(m_wr_n) * m_len);
        chk("wr_length", wr_length, m_len);
        chk("wr_size", {29'd0, wr_size}, 32'd3);
        chk("wr_count_bound", {31'd0, (m_wr_n < int'(m_tiles))}, 32'd1);
        if (wr_ready) m_wr_n++;
      end
      if (comp_start) begin
        chk("comp_start_single", {31'd0, prev_cs}, 32'd0);
        m_cs++;
      end
      if (acc_done) begin
        chk("acc_done_single", {31'd0, prev_acc}, 32'd0);
        m_acc++;
      end
      prev_cs  = comp_start;
      prev_acc = acc_done;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len, input logic [15:0] tiles, input bit hold);
    cfg_src_base = src; cfg_dst_base = dst; cfg_tile_len = len; cfg_num_tiles = tiles;
    m_src = src; m_dst = dst; m_len = len; m_tiles = tiles;
    m_rd_n = 0; m_wr_n = 0; m_cs = 0; m_acc = 0; cap_rd_n = 0; cap_wr_n = 0;
    rd_ready = hold; wr_ready = hold;
    conf_done = 1'b1;
    tick;
    conf_done = 1'b0;
  endtask

  task automatic do_req(input bit wr, input int delay, input bit hold, input int t);
    int g;
    logic [31:0] idx0;
    g = 0;
    while (!(wr ? wr_valid : rd_valid) && g < 40) begin tick; g++; end
    chk("valid_wait", {31'd0, (wr ? wr_valid : rd_valid)}, 32'd1);
    chk("req_state", {28'd0, debug[31:28]}, wr ? 32'd4 : 32'd1);
    chk("tile_idx", {16'd0, debug[15:0]}, 32'(t));
    idx0 = wr ? wr_index : rd_index;
    if (wr) begin cap_wr[cap_wr_n[2:0]] = idx0; cap_wr_n++; end
    else    begin cap_rd[cap_rd_n[2:0]] = idx0; cap_rd_n++; end
    for (int i = 0; i < delay; i++) begin
      if (wr) wr_ready = 1'b0; else rd_ready = 1'b0;
      tick;
      chk("valid_hold", {31'd0, (wr ? wr_valid : rd_valid)}, 32'd1);
      chk("payload_stable", wr ? wr_index : rd_index, idx0);
    end
    if (wr) wr_ready = 1'b1; else rd_ready = 1'b1;
    tick;
    if (!hold) begin rd_ready = 1'b0; wr_ready = 1'b0; end
    chk("valid_drop", {31'd0, (wr ? wr_valid : rd_valid)}, 32'd0);
  endtask

  task automatic do_beats(input bit wr, input int n, input bit stray_conf);
    for (int i = 0; i < n; i++) begin
      if (wr) wr_beat = 1'b1; else rd_beat = 1'b1;
      if (stray_conf && i == 0) begin
        conf_done = 1'b1; cfg_src_base = 32'hDEAD_0000; cfg_tile_len = 32'd1;
      end
      tick;
      conf_done = 1'b0;
    end
    rd_beat = 1'b0; wr_beat = 1'b0;
  endtask

  task automatic do_comp(input int delay, input bit stray, input bit early);
    chk("comp_start_latency", {31'd0, comp_start}, 32'd1);
    chk("comp_state", {28'd0, debug[31:28]}, 32'd3);
    comp_done = early;
    tick;
    comp_done = 1'b0;
    chk("comp_start_drop", {31'd0, comp_start}, 32'd0);
    chk("early_done_ignored", {31'd0, wr_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      rd_beat = (stray && i == 0);
      tick;
    end
    rd_beat = 1'b0;
    comp_done = 1'b1;
    tick;
    comp_done = 1'b0;
    chk("wr_valid_latency", {31'd0, wr_valid}, 32'd1);
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                         input logic [15:0] tiles, input int delay, input bit hold,
                         input bit stray, input bit early);
    start_job(src, dst, len, tiles, hold);
    chk("ovf_cleared_on_start", {31'd0, debug[27]}, 32'd0);
    if (len == 0 || tiles == 0) begin
      chk("degen_no_valid", {30'd0, rd_valid, wr_valid}, 32'd0);
      chk("degen_acc_n1", {31'd0, acc_done}, 32'd0);
      chk("degen_state", {28'd0, debug[31:28]}, 32'd6);
      tick;
      chk("degen_acc_n2", {31'd0, acc_done}, 32'd1);
      tick;
      chk("degen_acc_n3", {31'd0, acc_done}, 32'd0);
      chk("degen_idle", {28'd0, debug[31:28]}, 32'd0);
      chk("degen_rd_reqs", 32'(m_rd_n), 32'd0);
      chk("degen_wr_reqs", 32'(m_wr_n), 32'd0);
      chk("degen_acc_count", 32'(m_acc), 32'd1);
    end else begin
      chk("start_latency", {31'd0, rd_valid}, 32'd1);
      for (int t = 0; t < int'(tiles); t++) begin
        do_req(1'b0, delay, hold, t);
        do_beats(1'b0, int'(len), 1'b0);
        do_comp(10, stray && t == 0, early && t == 0);
        do_req(1'b1, delay, hold, t);
        do_beats(1'b1, int'(len), stray && t == 0);
        if (t == int'(tiles) - 1) chk("acc_latency", {31'd0, acc_done}, 32'd1);
        else                      chk("next_tile_latency", {31'd0, rd_valid}, 32'd1);
      end
      tick;
      chk("acc_drop", {31'd0, acc_done}, 32'd0);
      chk("back_to_idle", {28'd0, debug[31:28]}, 32'd0);
      chk("rd_reqs", 32'(m_rd_n), 32'(tiles));
      chk("wr_reqs", 32'(m_wr_n), 32'(tiles));
      chk("comp_starts", 32'(m_cs), 32'(tiles));
      chk("acc_count", 32'(m_acc), 32'd1);
      chk("ovf_flag", {31'd0, debug[27]}, {31'd0, stray});
    end
    rd_ready = 1'b0; wr_ready = 1'b0;
  endtask

  initial begin
    int acc_before;
    rst = 1'b0; conf_done = 1'b0; rd_ready = 1'b0; wr_ready = 1'b0;
    rd_beat = 1'b0; wr_beat = 1'b0; comp_done = 1'b0;
    cfg_src_base = '0; cfg_dst_base = '0; cfg_tile_len = '0; cfg_num_tiles = '0;
    m_src = '0; m_dst = '0; m_len = '0; m_tiles = '0;
    m_rd_n = 0; m_wr_n = 0; m_cs = 0; m_acc = 0; cap_rd_n = 0; cap_wr_n = 0;
    repeat (3) tick;
    chk("reset_ctrl", {28'd0, rd_valid, wr_valid, comp_start, acc_done}, 32'd0);
    chk("reset_payload", rd_index | rd_length | wr_index | wr_length, 32'd0);
    chk("reset_size", {26'd0, rd_size, wr_size}, {26'd0, 3'd3, 3'd3});
    chk("reset_debug", debug, 32'd0);
    rst = 1'b1;
    tick;

    // Single tile, ready always high.
    run_job(32'h100, 32'h800, 32'd4, 16'd1, 0, 1'b1, 1'b0, 1'b0);
    chk("lit_single_rd", cap_rd[0], 32'h100);
    chk("lit_single_wr", cap_wr[0], 32'h800);

    // Three tiles with 5-cycle backpressure and a start-coincident comp_done.
    run_job(32'h2000, 32'h3000, 32'd16, 16'd3, 5, 1'b0, 1'b0, 1'b1);
    chk("lit_multi_rd1", cap_rd[1], 32'h2010);
    chk("lit_multi_rd2", cap_rd[2], 32'h2020);
    chk("lit_multi_wr2", cap_wr[2], 32'h3020);

    // Degenerate jobs, ready held high to show it is ignored.
    run_job(32'h100, 32'h200, 32'd4, 16'd0, 0, 1'b1, 1'b0, 1'b0);
    run_job(32'h100, 32'h200, 32'd0, 16'd3, 0, 1'b1, 1'b0, 1'b0);

    // Index wrap.
    run_job(32'hFFFF_FFF8, 32'h10, 32'd8, 16'd2, 1, 1'b0, 1'b0, 1'b0);
    chk("lit_wrap_rd1", cap_rd[1], 32'h0000_0000);
    chk("lit_wrap_wr1", cap_wr[1], 32'h18);

    // Stray rd_beat in COMP and conf_done in WR_DATA, then a clean job clears the flag.
    run_job(32'h500, 32'h600, 32'd3, 16'd2, 0, 1'b0, 1'b1, 1'b0);
    run_job(32'h700, 32'h900, 32'd2, 16'd1, 0, 1'b1, 1'b0, 1'b0);

    // Reset during RD_DATA of tile 1.
    start_job(32'h40, 32'h400, 32'd4, 16'd2, 1'b1);
    do_req(1'b0, 0, 1'b1, 0);
    do_beats(1'b0, 4, 1'b0);
    do_comp(3, 1'b0, 1'b0);
    do_req(1'b1, 0, 1'b1, 0);
    do_beats(1'b1, 4, 1'b0);
    do_req(1'b0, 0, 1'b1, 1);
    rd_beat = 1'b1;
    tick;
    tick;
    chk("pre_reset_state", {28'd0, debug[31:28]}, 32'd2);
    acc_before = m_acc;
    #2 rst = 1'b0;
    #1;
    rd_beat = 1'b0;
    chk("async_reset_ctrl", {28'd0, rd_valid, wr_valid, comp_start, acc_done}, 32'd0);
    chk("async_reset_payload", rd_index | rd_length | wr_index | wr_length, 32'd0);
    chk("async_reset_debug", debug, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("reset_no_acc", {31'd0, acc_done}, 32'd0);
    end
    chk("reset_acc_count", 32'(m_acc), 32'(acc_before));
    rst = 1'b1;
    tick;
    run_job(32'h40, 32'h400, 32'd4, 16'd2, 2, 1'b0, 1'b0, 1'b0);
    chk("lit_after_reset_rd1", cap_rd[1], 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
